// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: opcodes, FSM states and
// datapath error bit positions.
package calc_pkg;

  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_CLR     = 4'b0001;
  localparam logic [3:0] OP_LOAD    = 4'b0010;
  localparam logic [3:0] OP_NOP_ALT = 4'b0011;
  localparam logic [3:0] OP_ADD     = 4'b0100;
  localparam logic [3:0] OP_SUB     = 4'b0101;
  localparam logic [3:0] OP_MUL     = 4'b0110;
  localparam logic [3:0] OP_DIV     = 4'b0111;
  localparam logic [3:0] OP_MOD     = 4'b1000;

  localparam int ERR_OVF  = 0;
  localparam int ERR_DIV0 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Everything above MOD in the 4-bit opcode space is reserved.
  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_MOD;
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Command and response handshakes between a host and the calculator sequencer.
interface calc_sequencer_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_operand;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_error;
  logic        rsp_illegal;

  modport master (
    output cmd_valid, cmd_opcode, cmd_operand, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_error, rsp_illegal
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_operand, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_error, rsp_illegal
  );

endinterface

// File: rtl/calc_sequencer.sv
// Sequential front-end for the combinational 16-bit calculator datapath:
// registers operands, captures results into an accumulator, returns responses.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// EXEC  | datapath settling on registered operands; capture at end of cycle
// RESP  | rsp_valid high, response held until rsp_ready
module calc_sequencer
  import calc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  calc_sequencer_if.slave    bus,
  output logic [31:0]        acc,
  output logic [1:0]         sticky_error,
  output logic [15:0]        alu_a,
  output logic [15:0]        alu_b,
  output logic [3:0]         alu_op,
  input  logic [31:0]        alu_result,
  input  logic [1:0]         alu_error
);

  state_e      state_q, state_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  sticky_q, sticky_d;
  logic [31:0] res_q, res_d;
  logic [1:0]  err_q, err_d;
  logic        ill_q, ill_d;

  always_comb begin
    state_d  = state_q;
    alu_op_d = alu_op_q;
    alu_b_d  = alu_b_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    res_d    = res_q;
    err_d    = err_q;
    ill_d    = ill_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          alu_op_d = bus.cmd_opcode;
          alu_b_d  = bus.cmd_operand;
          state_d  = EXEC;
        end
      end

      EXEC: begin
        state_d = RESP;
        res_d   = acc_q;
        err_d   = 2'b00;
        ill_d   = 1'b0;
        case (alu_op_q)
          OP_CLR: begin
            acc_d = 32'd0;
            res_d = 32'd0;
          end
          OP_LOAD: begin
            acc_d = sext16(alu_b_q);
            res_d = sext16(alu_b_q);
          end
          OP_ADD, OP_SUB, OP_MUL: begin
            acc_d = alu_result;
            res_d = alu_result;
            err_d = alu_error;
          end
          OP_DIV, OP_MOD: begin
            // A divide-by-zero result is reported but never lands in acc.
            res_d = alu_result;
            err_d = alu_error;
            if (!alu_error[ERR_DIV0]) acc_d = alu_result;
          end
          default: ill_d = is_illegal(alu_op_q);
        endcase
        sticky_d = (alu_op_q == OP_CLR) ? 2'b00 : (sticky_q | err_d);
      end

      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      alu_op_q <= 4'b0000;
      alu_b_q  <= 16'd0;
      acc_q    <= 32'd0;
      sticky_q <= 2'b00;
      res_q    <= 32'd0;
      err_q    <= 2'b00;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
      alu_b_q  <= alu_b_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      res_q    <= res_d;
      err_q    <= err_d;
      ill_q    <= ill_d;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_result  = res_q;
  assign bus.rsp_error   = err_q;
  assign bus.rsp_illegal = ill_q;

  // Only the low half of acc feeds back; the upper half is visible only.
  assign acc          = acc_q;
  assign sticky_error = sticky_q;
  assign alu_a        = acc_q[15:0];
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer with a behavioural calculator datapath
// and a response scoreboard.
module tb_calc_sequencer;
  import calc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] acc;
  logic [1:0]  sticky_error;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic [1:0]  alu_error;

  calc_sequencer_if bus ();

  calc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .acc          (acc),
    .sticky_error (sticky_error),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_error    (alu_error)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [1:0]  err;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_acc;
  logic [1:0]  model_sticky;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed 16-bit calculator datapath; returns {error, result}.
  function automatic logic [33:0] dp(input logic [15:0] a, input logic [15:0] b,
                                     input logic [3:0] op);
    int          ai, bi, r;
    logic [1:0]  e;
    logic [15:0] lo;
    ai = int'($signed(a));
    bi = int'($signed(b));
    r  = 0;
    e  = 2'b00;
    case (op)
      OP_ADD, OP_SUB: begin
        r  = (op == OP_ADD) ? ai + bi : ai - bi;
        if (r > 32767 || r < -32768) e[0] = 1'b1;
        lo = r[15:0];
        r  = int'($signed(lo));
      end
      OP_MUL: r = ai * bi;
      OP_DIV, OP_MOD: begin
        if (bi == 0) e[1] = 1'b1;
        else r = (op == OP_DIV) ? ai / bi : ai % bi;
      end
      default: r = 0;
    endcase
    return {e, r};
  endfunction

  always_comb {alu_error, alu_result} = dp(alu_a, alu_b, alu_op);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [3:0] op, input logic [15:0] b);
    exp_t        e;
    logic [33:0] d;
    e.res = model_acc;
    e.err = 2'b00;
    e.ill = 1'b0;
    d     = dp(model_acc[15:0], b, op);
    case (op)
      OP_NOP, OP_NOP_ALT: ;
      OP_CLR: begin model_acc = 32'd0; e.res = 32'd0; end
      OP_LOAD: begin model_acc = {{16{b[15]}}, b}; e.res = model_acc; end
      OP_ADD, OP_SUB, OP_MUL: begin
        model_acc = d[31:0]; e.res = d[31:0]; e.err = d[33:32];
      end
      OP_DIV, OP_MOD: begin
        e.res = d[31:0]; e.err = d[33:32];
        if (!d[33]) model_acc = d[31:0];
      end
      default: e.ill = 1'b1;
    endcase
    model_sticky = (op == OP_CLR) ? 2'b00 : (model_sticky | e.err);
    exp_q.push_back(e);
  endtask

  // Issue one command and follow it into RESP, checking the 2-cycle latency.
  task automatic send(input logic [3:0] op, input logic [15:0] b);
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin wait_clk(); n++; end
    if (!bus.cmd_ready) check_eq("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_opcode  = op;
    bus.cmd_operand = b;
    model_push(op, b);
    wait_clk();
    bus.cmd_valid = 1'b0;
    check_eq("lat_exec_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("lat_exec_ready", 32'(bus.cmd_ready), 32'd0);
    wait_clk();
    check_eq("lat_resp_valid", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic cmd(input logic [3:0] op, input logic [15:0] b);
    send(op, b);
    wait_clk();
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("rsp_result", bus.rsp_result, e.res);
        check_eq("rsp_error", 32'(bus.rsp_error), 32'(e.err));
        check_eq("rsp_illegal", 32'(bus.rsp_illegal), 32'(e.ill));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_opcode = 4'd0;
    bus.cmd_operand = 16'd0;
    bus.rsp_ready = 1'b0;
    model_acc = 32'd0;
    model_sticky = 2'b00;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_clk();
    check_eq("rst_acc", acc, 32'd0);
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_sticky", 32'(sticky_error), 32'd0);
    check_eq("rst_alu_b", 32'(alu_b), 32'd0);
    check_eq("rst_alu_op", 32'(alu_op), 32'd0);

    bus.rsp_ready = 1'b1;
    cmd(OP_LOAD, 16'd100);
    cmd(OP_ADD, 16'd150);
    check_eq("add_acc", acc, 32'd250);

    cmd(OP_LOAD, 16'h4844);
    cmd(OP_ADD, 16'h52EE);
    check_eq("ovf_acc", acc, 32'hFFFF9B32);
    check_eq("ovf_sticky", 32'(sticky_error), 32'd1);

    cmd(OP_LOAD, 16'd21);
    cmd(OP_DIV, 16'd0);
    check_eq("div0_acc", acc, 32'd21);
    check_eq("div0_sticky", 32'(sticky_error), 32'd3);
    cmd(OP_CLR, 16'd0);
    check_eq("clr_acc", acc, 32'd0);
    check_eq("clr_sticky", 32'(sticky_error), 32'd0);

    cmd(OP_LOAD, 16'hFFF9);
    check_eq("load_neg_acc", acc, 32'hFFFFFFF9);
    cmd(OP_SUB, 16'd3);
    cmd(OP_MOD, 16'd4);
    cmd(OP_DIV, 16'd2);
    cmd(OP_NOP, 16'd77);
    cmd(OP_NOP_ALT, 16'd5);
    check_eq("alu_a", 32'(alu_a), 32'(model_acc[15:0]));
    check_eq("mix_acc", acc, model_acc);

    cmd(OP_LOAD, 16'd477);
    bus.rsp_ready = 1'b0;
    send(OP_MUL, 16'd116);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.cmd_valid = 1'b0;
      check_eq("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("bp_rsp_result", bus.rsp_result, 32'd55332);
      check_eq("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      if (i == 1) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_opcode = OP_LOAD;
        bus.cmd_operand = 16'd999;
      end
      wait_clk();
    end
    bus.rsp_ready = 1'b1;
    check_eq("bp_hs_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    wait_clk();
    check_eq("bp_idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("bp_acc", acc, 32'd55332);

    cmd(4'b1011, 16'd5);
    check_eq("illegal_acc", acc, 32'd55332);

    bus.cmd_valid = 1'b1;
    bus.cmd_opcode = OP_ADD;
    bus.cmd_operand = 16'd1;
    wait_clk();
    bus.cmd_valid = 1'b0;
    check_eq("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rst_exec_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    model_acc = 32'd0;
    model_sticky = 2'b00;
    wait_clk();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_clk();
      check_eq("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    end
    check_eq("post_rst_acc", acc, 32'd0);
    cmd(OP_LOAD, 16'd12);
    check_eq("post_rst_load", acc, 32'd12);
    check_eq("final_sticky", 32'(sticky_error), 32'(model_sticky));

    wait_clk();
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
